fifo_axis_reader: RTL and testbench
===================================

# fifo_axis_reader

Downstream drain stage for the synchronous BRAM-backed FIFO controller. It converts the FIFO read interface (`fifo_rd_en`, one-cycle-latency `fifo_rd_data`, `fifo_empty`, `fifo_rd_err`) into an AXI-Stream master with registered outputs. It sustains one beat per cycle and generates `TLAST` from a programmable packet length. It sits between the FIFO controller and any AXIS consumer (DMA, HLS core input).

## Interface
- `DATA_WIDTH`, 32: width of FIFO words and `m_axis_tdata`.
- `LEN_WIDTH`, 16: width of the packet-length input and beat counter.
- `clk` input 1: single clock for all logic.
- `reset` input 1: synchronous, active-high reset.
- `fifo_rd_en` output 1: read strobe to FIFO controller.
- `fifo_rd_data` input DATA_WIDTH: FIFO read data, valid the cycle after an accepted `fifo_rd_en`.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_rd_err` input 1: FIFO flags the current `fifo_rd_en` as a read-from-empty.
- `pkt_len` input LEN_WIDTH: beats per packet; 0 = unframed stream (`TLAST` never asserted).
- `m_axis_tvalid` output 1: AXIS valid.
- `m_axis_tready` input 1: AXIS ready.
- `m_axis_tdata` output DATA_WIDTH: AXIS data.
- `m_axis_tlast` output 1: last beat of packet.
- `rd_err_count` output 16: saturating count of cancelled (errored) reads.

## Operation
- Internal 3-entry queue; the head entry drives `m_axis_tdata`/`m_axis_tlast`. `m_axis_tvalid` = queue non-empty, from a registered count.
- `inflight` register (0/1): set the cycle after a read is issued with `fifo_rd_en & ~fifo_rd_err`, otherwise cleared.
- `fifo_rd_en = ~reset & ~fifo_empty & (count + inflight < 3)`. This is combinational from registers and `fifo_empty` only, with no path from `m_axis_tready`.
- Push: when `inflight` = 1, `fifo_rd_data` is written to the tail that cycle.
- Pop: when `m_axis_tvalid & m_axis_tready`. Simultaneous push and pop leaves count unchanged; pushing into a 3-entry queue is impossible by the credit rule.
- Errored read (`fifo_rd_en & fifo_rd_err`): no data is expected or pushed. `rd_err_count` increments and saturates at 0xFFFF.
- Beat counter `beat_cnt` (LEN_WIDTH bits) counts accepted beats.
  - `m_axis_tlast` = `pkt_len != 0 && beat_cnt == pkt_len-1`.
  - On an accepted beat with tlast, `beat_cnt` goes to 0; otherwise it increments.
  - When `pkt_len` = 0, `beat_cnt` wraps modulo 2^LEN_WIDTH.
- `pkt_len` must be stable while a packet is in progress (`beat_cnt != 0`). A change there is undefined; the bench does not test it.
- AXIS rules:
  - Once `m_axis_tvalid` rises, `m_axis_tdata`/`m_axis_tlast` hold until the beat is accepted.
  - `m_axis_tvalid` never drops without acceptance.
- Reset values:
  - Outputs: `fifo_rd_en`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0 (given `pkt_len` != 1; the value is combinational from `beat_cnt`=0), `rd_err_count`=0.
  - Internal: count=0, inflight=0, `beat_cnt`=0.
- Reset mid-operation:
  - Queue contents and `beat_cnt` are discarded.
  - Data returning the cycle after reset for a pre-reset read is ignored, because inflight is cleared.

## Timing
- Read-to-valid latency is 2 cycles:
  - `fifo_rd_en` high in cycle N.
  - Data on `fifo_rd_data` in N+1, captured at the end of N+1.
  - `m_axis_tvalid`=1 in N+2.
- Sustained throughput is 1 beat/cycle with `tready`=1 and the FIFO non-empty. Steady state is count=1, inflight=1.
- With `tready`=0 the block issues at most 3 reads, then holds `fifo_rd_en`=0 until a pop.
- After a pop in cycle M, `fifo_rd_en` may reassert in M+1.
- `fifo_empty` is honoured combinationally in the same cycle. A `fifo_rd_en` into an empty or lagging-flag FIFO is tolerated via `fifo_rd_err`.

## Test plan
- Reset, then FIFO preloaded with 0x10..0x17, `pkt_len`=4, `tready`=1 -> `fifo_rd_en` high from cycle 0; `tvalid` first high at cycle 2. Beats 0x10..0x17 arrive on consecutive cycles, with `tlast` on 0x13 and 0x17.
- Same preload, `tready`=0 for 10 cycles -> exactly 3 `fifo_rd_en` pulses; `tdata`=0x10 held stable. Releasing `tready` delivers 0x10..0x17 in order with no gaps after the first beat.
- `tready` toggling 1/0 every cycle, 8 words, `pkt_len`=0 -> all 8 words delivered in order; `tlast` never asserted.
- Force `fifo_rd_err`=1 with `fifo_empty`=0 for 2 read cycles -> no beats produced from them; `rd_err_count`=2; subsequent valid reads deliver correct data.
- Assert `reset` for 1 cycle while 2 words are queued and 1 is in flight -> next cycle `tvalid`=0; the in-flight word is not emitted. The next packet starts with `beat_cnt`=0 (`tlast` on beat `pkt_len`-1).
- Drive `rd_err_count` to 0xFFFF with 65536 errored reads, then one more -> value stays 0xFFFF.

Source files
------------

// File: rtl/fifo_axis_reader.sv
// fifo_axis_reader: drains a one-cycle-latency FIFO read port into an
// AXI-Stream master. A 3-entry skid queue absorbs up to three outstanding
// reads, so the read strobe never depends on m_axis_tready and one beat per
// cycle is sustained. TLAST is framed from a programmable packet length.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   fifo_rd_en          - read strobe to the FIFO controller (combinational)
//   fifo_rd_data        - FIFO data, valid the cycle after an accepted read
//   fifo_empty          - FIFO empty flag, honoured in the same cycle
//   fifo_rd_err         - FIFO rejects the current read (read-from-empty)
//   pkt_len             - beats per packet, 0 = unframed stream
//   m_axis_tvalid/tready/tdata/tlast - AXI-Stream master
//   rd_err_count        - saturating count of rejected reads
module fifo_axis_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_rd_err,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [15:0]           rd_err_count
);

  localparam int unsigned DEPTH  = 3;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned ERR_W  = 16;
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  // Queue storage; entry 0 is the head presented on the stream.
  logic [DATA_WIDTH-1:0] q_mem [DEPTH];
  logic [DATA_WIDTH-1:0] q_d   [DEPTH];

  logic [CNT_W-1:0]     count_q,    count_d;
  logic                 valid_q,    valid_d;
  logic                 inflight_q, inflight_d;
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [ERR_W-1:0]     err_cnt_q,  err_cnt_d;

  logic             push;
  logic             pop;
  logic             tlast_c;
  logic [CNT_W:0]   credit_used;
  logic [CNT_W-1:0] wr_idx;

  // Credits: entries held plus the read still in flight must fit the queue.
  assign credit_used = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
  assign fifo_rd_en  = ~reset & ~fifo_empty & (credit_used < (CNT_W+1)'(DEPTH));

  assign push = inflight_q;
  assign pop  = valid_q & m_axis_tready;

  // Last beat of a packet; never set for an unframed stream.
  assign tlast_c = (pkt_len != '0) && (beat_cnt_q == pkt_len - LEN_WIDTH'(1));

  // Tail slot for the incoming word, accounting for a same-cycle pop.
  assign wr_idx = pop ? (count_q - CNT_W'(1)) : count_q;

  // Queue next state: shift on pop, then write the returning word at the tail.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      q_d[i] = q_mem[i];
    end
    if (pop) begin
      q_d[0] = q_mem[1];
      q_d[1] = q_mem[2];
    end
    if (push) begin
      case (wr_idx)
        2'd0:    q_d[0] = fifo_rd_data;
        2'd1:    q_d[1] = fifo_rd_data;
        2'd2:    q_d[2] = fifo_rd_data;
        default: ;
      endcase
    end
  end

  // Occupancy, valid, in-flight tracking, beat framing and error counter.
  always_comb begin
    count_d    = count_q;
    valid_d    = valid_q;
    inflight_d = 1'b0;
    beat_cnt_d = beat_cnt_q;
    err_cnt_d  = err_cnt_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);

    // A rejected read returns no data, so it must not occupy a credit.
    inflight_d = fifo_rd_en & ~fifo_rd_err;

    if (pop) begin
      beat_cnt_d = tlast_c ? '0 : beat_cnt_q + LEN_WIDTH'(1);
    end

    if (fifo_rd_en && fifo_rd_err && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  // State registers; reset discards queued words and any read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_mem[i] <= '0;
      end
      count_q    <= '0;
      valid_q    <= 1'b0;
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_mem[i] <= q_d[i];
      end
      count_q    <= count_d;
      valid_q    <= valid_d;
      inflight_q <= inflight_d;
      beat_cnt_q <= beat_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign m_axis_tvalid = valid_q;
  assign m_axis_tdata  = q_mem[0];
  assign m_axis_tlast  = tlast_c;
  assign rd_err_count  = err_cnt_q;

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Bench for fifo_axis_reader: a behavioural FIFO feeds the DUT, a forked
// monitor keeps a scoreboard of words read (minus those lost to reset) and
// checks order, framing, AXIS hold rules and the error counter every cycle.
module tb_fifo_axis_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_empty;
  logic          fifo_rd_err;
  logic [LW-1:0] pkt_len;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic [15:0]   rd_err_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural FIFO: array plus read/write pointers.
  logic [DW-1:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;

  // Monitor state
  logic [DW-1:0] sb[$];
  int beat_k = 0;
  int exp_err = 0;
  int acc_total = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_rd_err) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end else begin
      fifo_rd_data <= $urandom;
    end
  end

  fifo_axis_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_empty    (fifo_empty),
    .fifo_rd_err   (fifo_rd_err),
    .pkt_len       (pkt_len),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .rd_err_count  (rd_err_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic begin_reset(input logic [LW-1:0] len);
    reset = 1'b1;
    pkt_len = len;
    m_axis_tready = 1'b0;
    fifo_rd_err = 1'b0;
    step();
  endtask

  task automatic end_reset();
    step();
    reset = 1'b0;
  endtask

  // Sampled mid-cycle: reflects state after the last edge and the
  // handshake that the next edge will perform.
  task automatic monitor();
    bit prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    bit exp_last;
    forever begin
      @(negedge clk);
      if (!reset) begin
        n_cmp++;
        if (rd_err_count !== 16'(exp_err)) begin
          n_bad++;
          $display("FAIL mon_err_count: got %h want %h", rd_err_count, 16'(exp_err));
        end
        if (prev_stall) begin
          n_cmp++;
          if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
            n_bad++;
            $display("FAIL mon_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
          end
        end
        if (m_axis_tvalid === 1'b1) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL mon_spurious_valid: got data %h want no beat", m_axis_tdata);
          end else if (m_axis_tdata !== sb[0]) begin
            n_bad++;
            $display("FAIL mon_data: got %h want %h", m_axis_tdata, sb[0]);
          end
          if (m_axis_tready) begin
            exp_last = (pkt_len != '0) && (((beat_k + 1) % int'(pkt_len)) == 0);
            n_cmp++;
            if (m_axis_tlast !== exp_last) begin
              n_bad++;
              $display("FAIL mon_tlast: beat %0d got %b want %b", beat_k, m_axis_tlast, exp_last);
            end
            if (sb.size() > 0) void'(sb.pop_front());
            beat_k++;
            acc_total++;
          end
        end
        prev_stall = (m_axis_tvalid === 1'b1) && !m_axis_tready;
        prev_data = m_axis_tdata;
        prev_last = m_axis_tlast;
        if (fifo_rd_en && fifo_rd_err && exp_err < 65535) exp_err++;
        if (fifo_rd_en && !fifo_rd_err) sb.push_back(mem[rd_ptr]);
      end else begin
        sb.delete();
        beat_k = 0;
        exp_err = 0;
        prev_stall = 0;
      end
    end
  endtask

  task automatic test_reset();
    step();
    step();
    @(negedge clk);
    n_cmp++;
    if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    n_cmp++;
    if (m_axis_tdata !== '0) begin n_bad++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
    n_cmp++;
    if (m_axis_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
    n_cmp++;
    if (rd_err_count !== 16'h0) begin n_bad++; $display("FAIL reset_err_count: got %h want 0", rd_err_count); end
    step();
  endtask

  task automatic test_stream();
    begin_reset(16'd4);
    for (int i = 0; i < 8; i++) push_word(DW'(32'h10 + i));
    end_reset();
    m_axis_tready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_cmp++;
        if (fifo_rd_en !== 1'b1) begin n_bad++; $display("FAIL stream_rd_en_c0: got %b want 1", fifo_rd_en); end
      end
      if (c < 2) begin
        n_cmp++;
        if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid: cycle %0d got %b want 0", c, m_axis_tvalid); end
      end else begin
        n_cmp++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== DW'(32'h10 + c - 2) || m_axis_tlast !== (((c - 2) % 4) == 3)) begin
          n_bad++;
          $display("FAIL stream_beat: cycle %0d got v=%b d=%h l=%b want v=1 d=%h l=%b", c, m_axis_tvalid,
                   m_axis_tdata, m_axis_tlast, DW'(32'h10 + c - 2), (((c - 2) % 4) == 3));
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int pulses = 0;
    int got = 0;
    int gaps = 0;
    begin_reset(16'd4);
    for (int i = 0; i < 8; i++) push_word(DW'(32'h10 + i));
    end_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) pulses++;
      if (c >= 2) begin
        n_cmp++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== DW'(32'h10)) begin
          n_bad++;
          $display("FAIL bp_hold_head: cycle %0d got v=%b d=%h want v=1 d=00000010", c, m_axis_tvalid, m_axis_tdata);
        end
      end
      step();
    end
    n_cmp++;
    if (pulses != 3) begin n_bad++; $display("FAIL bp_read_pulses: got %0d want 3", pulses); end
    m_axis_tready = 1'b1;
    for (int c = 0; c < 30 && got < 8; c++) begin
      @(negedge clk);
      if (m_axis_tvalid === 1'b1) begin
        n_cmp++;
        if (m_axis_tdata !== DW'(32'h10 + got)) begin
          n_bad++;
          $display("FAIL bp_order: got %h want %h", m_axis_tdata, DW'(32'h10 + got));
        end
        got++;
      end else begin
        gaps++;
      end
      step();
    end
    n_cmp++;
    if (got != 8 || gaps != 0) begin n_bad++; $display("FAIL bp_release: got %0d beats %0d gaps want 8 beats 0 gaps", got, gaps); end
  endtask

  task automatic test_toggle();
    int got = 0;
    begin_reset(16'd0);
    for (int i = 0; i < 8; i++) push_word(DW'(32'h20 + i));
    end_reset();
    for (int c = 0; c < 60 && got < 8; c++) begin
      m_axis_tready = c[0];
      @(negedge clk);
      if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
        n_cmp++;
        if (m_axis_tdata !== DW'(32'h20 + got) || m_axis_tlast !== 1'b0) begin
          n_bad++;
          $display("FAIL toggle_beat: got d=%h l=%b want d=%h l=0", m_axis_tdata, m_axis_tlast, DW'(32'h20 + got));
        end
        got++;
      end
      step();
    end
    n_cmp++;
    if (got != 8) begin n_bad++; $display("FAIL toggle_count: got %0d want 8", got); end
  endtask

  task automatic test_rd_err();
    int got = 0;
    begin_reset(16'd0);
    for (int i = 0; i < 4; i++) push_word(DW'(32'h40 + i));
    end_reset();
    m_axis_tready = 1'b1;
    for (int c = 0; c < 30 && got < 4; c++) begin
      fifo_rd_err = (c < 2);
      @(negedge clk);
      if (c < 2) begin
        n_cmp++;
        if (fifo_rd_en !== 1'b1) begin n_bad++; $display("FAIL err_read_issued: cycle %0d got %b want 1", c, fifo_rd_en); end
      end
      if (c < 4) begin
        n_cmp++;
        if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL err_no_beat: cycle %0d got %b want 0", c, m_axis_tvalid); end
      end
      if (m_axis_tvalid === 1'b1) begin
        n_cmp++;
        if (m_axis_tdata !== DW'(32'h40 + got)) begin
          n_bad++;
          $display("FAIL err_data: got %h want %h", m_axis_tdata, DW'(32'h40 + got));
        end
        got++;
      end
      step();
    end
    @(negedge clk);
    n_cmp++;
    if (got != 4 || rd_err_count !== 16'd2) begin
      n_bad++;
      $display("FAIL err_summary: got %0d beats count %0d want 4 beats count 2", got, rd_err_count);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int got = 0;
    begin_reset(16'd3);
    for (int i = 0; i < 6; i++) push_word(DW'(32'h30 + i));
    end_reset();
    step();
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL mid_rd_en_in_reset: got %b want 0", fifo_rd_en); end
    step();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL mid_tvalid_after_reset: got %b want 0", m_axis_tvalid); end
    step();
    m_axis_tready = 1'b1;
    for (int c = 0; c < 30 && got < 3; c++) begin
      @(negedge clk);
      if (m_axis_tvalid === 1'b1) begin
        n_cmp++;
        if (m_axis_tdata !== DW'(32'h33 + got) || m_axis_tlast !== (got == 2)) begin
          n_bad++;
          $display("FAIL mid_beat: got d=%h l=%b want d=%h l=%b", m_axis_tdata, m_axis_tlast,
                   DW'(32'h33 + got), (got == 2));
        end
        got++;
      end
      step();
    end
    n_cmp++;
    if (got != 3) begin n_bad++; $display("FAIL mid_count: got %0d want 3", got); end
  endtask

  task automatic test_err_saturate();
    int got = 0;
    begin_reset(16'd0);
    push_word(DW'(32'h55));
    end_reset();
    m_axis_tready = 1'b1;
    fifo_rd_err = 1'b1;
    repeat (65536) step();
    @(negedge clk);
    n_cmp++;
    if (rd_err_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_at_max: got %h want ffff", rd_err_count); end
    step();
    @(negedge clk);
    n_cmp++;
    if (rd_err_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold: got %h want ffff", rd_err_count); end
    step();
    fifo_rd_err = 1'b0;
    for (int c = 0; c < 10 && got < 1; c++) begin
      @(negedge clk);
      if (m_axis_tvalid === 1'b1) begin
        n_cmp++;
        if (m_axis_tdata !== DW'(32'h55)) begin n_bad++; $display("FAIL sat_data: got %h want 00000055", m_axis_tdata); end
        got++;
      end
      step();
    end
    n_cmp++;
    if (got != 1) begin n_bad++; $display("FAIL sat_drain: got %0d want 1", got); end
  endtask

  task automatic test_random();
    int pushed = 0;
    int base;
    begin_reset(LW'($urandom_range(0, 5)));
    end_reset();
    base = acc_total;
    for (int c = 0; c < 400; c++) begin
      m_axis_tready = ($urandom % 4) != 0;
      fifo_rd_err = ($urandom % 10) == 0;
      if (($urandom % 3) != 0 && pushed < 200) begin
        push_word(DW'($urandom));
        pushed++;
      end
      @(negedge clk);
      step();
    end
    fifo_rd_err = 1'b0;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 300 && (acc_total - base) < pushed; c++) begin
      step();
    end
    @(negedge clk);
    n_cmp++;
    if ((acc_total - base) != pushed || sb.size() != 0) begin
      n_bad++;
      $display("FAIL random_drain: got %0d beats (%0d pending) want %0d", acc_total - base, sb.size(), pushed);
    end
    step();
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    m_axis_tready = 1'b0;
    fifo_rd_err = 1'b0;
    pkt_len = 16'd4;
    fork
      monitor();
    join_none
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_rd_err();
    test_reset_mid();
    test_random();
    test_err_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
